// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad front end: column scan, row synchronizer, lowest-index key
// selection and multi-scan debounce producing a stable key code and press event.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [7:0] keypad,
  output logic       keyEvent
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CNT);
  // Bit 4 set marks "no key"; otherwise bits 3:0 are the key index.
  localparam logic [4:0] NONE = 5'h10;

  logic [3:0]       rowsSync1;
  logic [3:0]       rowsSync2;
  logic [3:0]       rs;
  logic [DIV_W-1:0] divCnt;
  logic [1:0]       colIdx;
  logic [11:0]      snapshot;
  logic [4:0]       candReg;
  logic [CNT_W-1:0] stableCnt;
  logic             sampleEdge;
  logic [4:0]       cand;
  logic [4:0]       keypadCode;
  logic [CNT_W-1:0] nextCnt;

  function automatic logic [4:0] lowestKey(input logic [15:0] closed);
    lowestKey = NONE;
    for (int i = 15; i >= 0; i--) begin
      if (closed[i]) lowestKey = {1'b0, 4'(i)};
    end
  endfunction

  assign rs         = ~rowsSync2;
  assign cols       = ~(4'b0001 << colIdx);
  assign sampleEdge = (divCnt == DIV_LAST);
  // Column 3 is taken straight from the synchronizer so the commit sees this scan.
  assign cand       = lowestKey({rs, snapshot});
  assign keypadCode = keypad[7] ? {1'b0, keypad[3:0]} : NONE;

  always_comb begin
    nextCnt = CNT_W'(1);
    if (cand == candReg) begin
      nextCnt = (stableCnt == CNT_MAX) ? stableCnt : stableCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rowsSync1 <= 4'b1111;
      rowsSync2 <= 4'b1111;
      divCnt    <= '0;
      colIdx    <= 2'd0;
      snapshot  <= '0;
      candReg   <= NONE;
      stableCnt <= CNT_MAX;
      keypad    <= 8'h00;
      keyEvent  <= 1'b0;
    end else begin
      rowsSync1 <= rows;
      rowsSync2 <= rowsSync1;
      keyEvent  <= 1'b0;
      divCnt    <= divCnt + 1'b1;
      if (sampleEdge) begin
        divCnt <= '0;
        colIdx <= colIdx + 2'd1;
        case (colIdx)
          2'd0: snapshot[3:0]  <= rs;
          2'd1: snapshot[7:4]  <= rs;
          2'd2: snapshot[11:8] <= rs;
          default: begin
            candReg   <= cand;
            stableCnt <= nextCnt;
            if (nextCnt == CNT_MAX && cand != keypadCode) begin
              keypad   <= cand[4] ? 8'h00 : {1'b1, 3'b000, cand[3:0]};
              keyEvent <= ~cand[4];
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=2 and a
// behavioural 4x4 key matrix driven from a held-key mask.
module tb_keypad_scanner;

  localparam int SCAN = 16;

  logic        clk;
  logic        reset;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [7:0]  keypad;
  logic        keyEvent;
  logic [15:0] keys;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        doReset;
    logic [15:0] keys;
    logic [7:0]  expKeypad;
    int          expEvents;
  } vec_t;

  vec_t vecs[15];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(2)) dut (
    .clk(clk),
    .reset(reset),
    .rows(rows),
    .cols(cols),
    .keypad(keypad),
    .keyEvent(keyEvent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a held key pulls its row low while its column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!cols[c]) rows = rows & ~keys[c*4 +: 4];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic resetDut();
    reset = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic runScan(output int ev);
    ev = 0;
    for (int c = 0; c < SCAN; c++) begin
      @(posedge clk);
      #1;
      if (keyEvent) ev++;
    end
  endtask

  initial begin
    int ev;
    logic [3:0] expCols;

    vecs[0]  = '{1'b1, 16'h0000, 8'h00, 0};
    vecs[1]  = '{1'b1, 16'h0040, 8'h00, 0};
    vecs[2]  = '{1'b0, 16'h0040, 8'h86, 1};
    vecs[3]  = '{1'b0, 16'h0040, 8'h86, 0};
    vecs[4]  = '{1'b0, 16'h0000, 8'h86, 0};
    vecs[5]  = '{1'b0, 16'h0000, 8'h00, 0};
    vecs[6]  = '{1'b0, 16'h0000, 8'h00, 0};
    vecs[7]  = '{1'b1, 16'h0040, 8'h00, 0};
    vecs[8]  = '{1'b0, 16'h0000, 8'h00, 0};
    vecs[9]  = '{1'b0, 16'h0000, 8'h00, 0};
    vecs[10] = '{1'b1, 16'h0208, 8'h00, 0};
    vecs[11] = '{1'b0, 16'h0208, 8'h83, 1};
    vecs[12] = '{1'b0, 16'h0200, 8'h83, 0};
    vecs[13] = '{1'b0, 16'h0200, 8'h89, 1};
    vecs[14] = '{1'b0, 16'h0200, 8'h89, 0};

    // Reset state and column rotation with no keys.
    keys  = 16'h0000;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("resetCols", 32'(cols), 32'h0E);
    check("resetKeypad", 32'(keypad), 32'h00);
    check("resetEvent", 32'(keyEvent), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= SCAN; k++) begin
      @(posedge clk);
      #1;
      expCols = ~(4'b0001 << ((k / 4) % 4));
      check($sformatf("colsEdge%0d", k), 32'(cols), 32'(expCols));
      check($sformatf("idleKeypad%0d", k), 32'(keypad), 32'h00);
    end

    for (int i = 0; i < 15; i++) begin
      keys = vecs[i].keys;
      if (vecs[i].doReset) resetDut();
      runScan(ev);
      check($sformatf("vec%0dKeypad", i), 32'(keypad), 32'(vecs[i].expKeypad));
      check($sformatf("vec%0dEvents", i), 32'(ev), 32'(vecs[i].expEvents));
    end

    // Reset asserted mid-scan (colIdx 2, divCnt 2) with key 6 committed.
    keys = 16'h0040;
    resetDut();
    runScan(ev);
    runScan(ev);
    check("preResetKeypad", 32'(keypad), 32'h86);
    check("preResetEvents", 32'(ev), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midResetKeypad", 32'(keypad), 32'h00);
    check("midResetCols", 32'(cols), 32'h0E);
    check("midResetEvent", 32'(keyEvent), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    runScan(ev);
    check("requalScan1Keypad", 32'(keypad), 32'h00);
    check("requalScan1Events", 32'(ev), 32'd0);
    runScan(ev);
    check("requalScan2Keypad", 32'(keypad), 32'h86);
    check("requalScan2Events", 32'(ev), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream front end for the SOC `keypad[7:0]` input; the SOC memory-maps this byte through its IO module.
- Drives a 4x4 matrix keypad one column at a time and samples the four row lines through a synchronizer.
- Debounces the result over several full scans and presents a stable key code plus a one-cycle new-press event.

Parameters:
- SCAN_DIV, 1000: clk cycles each column is driven; must be >= 4.
- DEBOUNCE_CNT, 4: identical consecutive full-scan results required before the output changes; must be >= 1.

Ports:
- clk  input  1  system clock (SOC fastClk domain).
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- rows  input  4  keypad row lines; active-low (0 = key closed), asynchronous to clk.
- cols  output  4  column drive; exactly one bit low, others high.
- keypad  output  8  debounced code: bit7 = key held, bits6:4 = 0, bits3:0 = key index.
- keyEvent  output  1  one-cycle pulse when a new debounced press is committed.

Behaviour:
- Key index = colIdx*4 + rowIdx. colIdx is the position of the low bit in cols; rowIdx is the position of the low bit in rows.
- Reset values (async, reset=0):
  - cols=4'b1110 (colIdx 0), divCnt=0, snapshot=0.
  - keypad=8'h00, keyEvent=0.
  - candidate register = NONE, stableCnt = DEBOUNCE_CNT.
  - Sync flops are reset to 4'b1111.
- Row sync: 2-flop synchronizer; `rs` = inverted output of the second flop, so 1 = closed.
- Column timer:
  - divCnt counts 0..SCAN_DIV-1 while the current column is driven.
  - On the edge where divCnt==SCAN_DIV-1 (the sample edge):
    - snapshot[colIdx*4 +: 4] <= rs.
    - divCnt <= 0; cols rotates left by one: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - A full scan is 4*SCAN_DIV cycles.
- Scan commit, on the sample edge of colIdx 3:
  - cand = lowest set index of {rs, snapshot[11:0]}, using the merged current value for column 3.
  - cand = NONE if no bit is set. Multiple keys: the lowest index wins.
- Debounce, same edge:
  - If cand == candidate register: stableCnt <= min(stableCnt+1, DEBOUNCE_CNT).
  - Otherwise: candidate register <= cand, stableCnt <= 1.
  - Call the new stableCnt value S.
  - If S == DEBOUNCE_CNT and cand differs from the current keypad value:
    - keypad <= {1'b1, 3'b0, cand}, or 8'h00 if cand is NONE.
  - keyEvent <= 1 only when keypad is updated to a pressed code. This includes a direct change from key A to key B.
  - A release never produces keyEvent.
- keyEvent is high for exactly one cycle (the cycle after the commit edge) and is 0 at all other times.
- Latency: with DEBOUNCE_CNT=N, a press that is stable from the start of a scan commits at the end of the Nth scan.
- Reset mid-scan: all state returns to reset values immediately. Scanning restarts at colIdx 0 with divCnt=0 when reset deasserts. A held key must re-qualify through the full debounce.
- Row inputs are ignored except at sample edges. Glitches between samples have no effect.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=2; full scan = 16 cycles):
1. Hold reset=0, then release, rows=4'hF:
   - During reset: cols=1110, keypad=00, keyEvent=0.
   - After release: cols goes 1101, 1011, 0111, 1110 at 4-cycle intervals; keypad stays 00.
2. Drive rows[2]=0 whenever cols==1101 (key 6) from reset release:
   - keypad stays 00 after scan 1.
   - keypad=8'h86 at the scan-2 commit edge.
   - keyEvent pulses exactly once; no further pulses while held.
3. Key 6 present in scan 1 only, absent in scan 2 (bounce): keypad remains 00 and keyEvent never asserts.
4. Key 6 committed, then released:
   - keypad=8'h86 through the first released scan.
   - keypad=8'h00 at the second released scan commit; no keyEvent.
5. Keys 3 (col0,row3) and 9 (col2,row1) held together: keypad=8'h83 after two scans.
   - Then release key 3 only: keypad=8'h89 after two more scans, with one keyEvent.
6. Key 6 committed, assert reset mid-scan (divCnt=2, colIdx=2):
   - keypad=00 and cols=1110 immediately.
   - After release with the key still held: keypad=8'h86 again after two full scans, with one keyEvent.
